// File: rtl/mctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, instruction
// classes, opcode/funct constants, ALU operation codes and PC/writeback selects.
// Purely declarative; no timing or backpressure of its own.
package mctrl_pkg;

  // Controller states. Every instruction starts in FETCH; TRAP is terminal
  // until reset.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_JAL = 3'd5
  } ins_cls_e;

  // Major opcodes (ins[6:0]).
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // funct3 values (ins[14:12]).
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // funct7 values (ins[31:25]); ALT selects sub for funct3 000.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select.
  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Register-file writeback select.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // True for the four funct3 codes the ALU-class instructions support.
  function automatic logic f3_is_alu(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR) || (f3 == F3_SLT);
  endfunction

  // funct3 -> ALU op; alt picks sub over add (only meaningful for R-type).
  function automatic logic [2:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    logic [2:0] op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_AND:  op = ALU_AND;
      F3_OR:   op = ALU_OR;
      F3_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multicycle controller and its datapath.
// Latency: none (wires only).
// Backpressure: mem_ack from the datapath stalls FETCH and MEM.
// Ports: ins/zero/mem_ack flow datapath -> controller; strobes, selects,
//        illegal and instret flow controller -> datapath.
interface multicycle_ctrl_if #(
  parameter int INSTRET_W = 32
);
  import mctrl_pkg::*;

  logic [31:0]          ins;
  logic                 zero;
  logic                 mem_ack;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_src;
  logic                 reg_write;
  logic                 alu_src;
  logic [2:0]           alu_op;
  logic [1:0]           wb_sel;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  // Controller side.
  modport master (
    input  ins, zero, mem_ack,
    output mem_read, mem_write, ir_we, pc_we, pc_src,
           reg_write, alu_src, alu_op, wb_sel, illegal, instret
  );

  // Datapath side.
  modport slave (
    output ins, zero, mem_ack,
    input  mem_read, mem_write, ir_we, pc_we, pc_src,
           reg_write, alu_src, alu_op, wb_sel, illegal, instret
  );
endinterface

// File: rtl/mctrl_decode.sv
// Combinational instruction decoder: opcode/funct fields -> class, ALU op,
// ALU source select and illegal flag. Latency: 0 cycles. No backpressure.
// Ports: opcode_i/funct3_i/funct7_i in; alu_op_o, alu_src_o, ins_cls_o, illegal_o out.
// Config: MCTRL_JAL_EN defined makes opcode 1101111 (jal) legal; otherwise it
//         falls into the illegal default.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output ins_cls_e   ins_cls_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    ins_cls_o = CLS_R;
    illegal_o = 1'b1;
    case (opcode_i)
      OPC_R: begin
        ins_cls_o = CLS_R;
        alu_op_o  = alu_op_from_f3(funct3_i, funct7_i[5]);
        // funct7 must be all-zero, except the sub encoding of funct3 000.
        illegal_o = !(f3_is_alu(funct3_i) &&
                      ((funct7_i == F7_BASE) ||
                       ((funct7_i == F7_ALT) && (funct3_i == F3_ADD))));
      end
      OPC_I: begin
        // funct7 bits belong to the immediate here, so they are ignored.
        ins_cls_o = CLS_I;
        alu_op_o  = alu_op_from_f3(funct3_i, 1'b0);
        alu_src_o = 1'b1;
        illegal_o = !f3_is_alu(funct3_i);
      end
      OPC_LW: begin
        ins_cls_o = CLS_LW;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b1;
        illegal_o = (funct3_i != F3_WORD);
      end
      OPC_SW: begin
        ins_cls_o = CLS_SW;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b1;
        illegal_o = (funct3_i != F3_WORD);
      end
      OPC_BEQ: begin
        ins_cls_o = CLS_BEQ;
        alu_op_o  = ALU_SUB;
        illegal_o = (funct3_i != F3_BEQ);
      end
`ifdef MCTRL_JAL_EN
      OPC_JAL: begin
        ins_cls_o = CLS_JAL;
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FSM sequencing FETCH/DECODE/EXEC/MEM/WB/TRAP,
// sticky illegal flag and retired-instruction counter.
// Latency: R/I 4, lw 5, sw 4, beq/jal 3 cycles; FETCH and MEM stall while
// mem_ack is low (each low cycle adds one).
// Ports: clk, reset (synchronous, active-high); bus (multicycle_ctrl_if.master)
//        carrying ins/zero/mem_ack in and all strobes, selects, illegal, instret out.
// Config: MCTRL_JAL_EN enables jal; without it jal traps and pc_src=10 /
//         wb_sel=10 are never produced.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  ins_cls_e   dec_cls;
  logic       dec_illegal;

  // Unqualified outputs of the FSM; reset masking is applied at the boundary.
  logic       mem_read, mem_write, ir_we, pc_we, reg_write, alu_src;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op;
  logic       retire;

  mctrl_decode u_decode (
    .opcode_i  (bus.ins[6:0]),
    .funct3_i  (bus.ins[14:12]),
    .funct7_i  (bus.ins[31:25]),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .ins_cls_o (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    reg_write = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_op    = ALU_AND;
    alu_src   = 1'b0;

    // The IR holds a valid instruction from DECODE to WB; outside that window
    // the ALU controls are parked at zero.
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
        (state_q == ST_MEM)    || (state_q == ST_WB)) begin
      alu_op  = dec_alu_op;
      alu_src = dec_alu_src;
    end

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_illegal) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (dec_cls)
          CLS_R, CLS_I:   state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BEQ: begin
            pc_we   = bus.zero;
            pc_src  = PC_SRC_BRANCH;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
`ifdef MCTRL_JAL_EN
          CLS_JAL: begin
            pc_we     = 1'b1;
            pc_src    = PC_SRC_JUMP;
            reg_write = 1'b1;
            wb_sel    = WB_SEL_PC4;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end
`endif
          default: begin
            // Unreachable when DECODE screened the instruction; trap defensively.
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end

      ST_MEM: begin
        mem_read  = (dec_cls == CLS_LW);
        mem_write = (dec_cls == CLS_SW);
        if (bus.mem_ack) begin
          if (dec_cls == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (dec_cls == CLS_LW) ? WB_SEL_MEM : WB_SEL_ALU;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_TRAP: ;

      default: state_d = ST_FETCH;
    endcase

    // Counter wraps naturally at 2^INSTRET_W.
    instret_d = retire ? (instret_q + INSTRET_W'(1)) : instret_q;
  end

  // All outputs read as zero during the reset cycle, whatever state was left behind.
  assign bus.mem_read  = mem_read  & ~reset;
  assign bus.mem_write = mem_write & ~reset;
  assign bus.ir_we     = ir_we     & ~reset;
  assign bus.pc_we     = pc_we     & ~reset;
  assign bus.reg_write = reg_write & ~reset;
  assign bus.alu_src   = alu_src   & ~reset;
  assign bus.pc_src    = reset ? 2'b00 : pc_src;
  assign bus.wb_sel    = reset ? 2'b00 : wb_sel;
  assign bus.alu_op    = reset ? 3'b000 : alu_op;
  assign bus.illegal   = illegal_q & ~reset;
  assign bus.instret   = reset ? '0 : instret_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter INSTRET_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge; reset is synchronous and active-high.
REQ-003 SHALL have port reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port ins  in  32  instruction register contents, decoded in DECODE/EXEC/MEM/WB.
REQ-005 SHALL have port zero  in  1  ALU zero flag, sampled in EXEC.
REQ-006 SHALL have port mem_ack  in  1  memory completion, one-cycle pulse or level.
REQ-007 SHALL have ports mem_read, mem_write  out  1 each  memory strobes.
REQ-008 SHALL have ports ir_we, pc_we  out  1 each  instruction-register and PC write enables.
REQ-009 SHALL have port pc_src  out  2  00 PC+4, 01 branch target (old PC), 10 jump target (old PC).
REQ-010 SHALL have ports reg_write, alu_src  out  1 each; alu_op  out  3  (000 and, 001 or, 010 add, 110 sub, 111 slt).
REQ-011 SHALL have port wb_sel  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 SHALL have ports illegal  out  1  sticky trap flag; instret  out  INSTRET_W  retired count.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-014 FETCH SHALL assert mem_read; it SHALL hold until mem_ack=1; that cycle, ir_we=1, pc_we=1, pc_src=00; next DECODE.
REQ-015 DECODE SHALL last one cycle with all strobes 0; next EXEC, or TRAP if opcode/funct illegal.
REQ-016 Supported: R 0110011 (add, sub, and, or, slt), I 0010011 (addi, andi, ori, slti), lw 0000011, sw 0100011, beq 1100011, jal 1101111; any other opcode, funct3 or funct7 is illegal.
REQ-017 alu_op decode: funct3 000 -> 010, or 110 if R and funct7[5]=1; funct3 111 -> 000; funct3 110 -> 001; funct3 010 -> 111. lw/sw -> 010; beq -> 110.
REQ-018 alu_src SHALL be 1 for I, lw and sw; it SHALL be 0 otherwise.
REQ-019 EXEC for R/I: next WB. For lw/sw: next MEM.
REQ-020 EXEC for beq: pc_we=zero, pc_src=01; next FETCH.
REQ-021 EXEC for jal: pc_we=1, pc_src=10, reg_write=1, wb_sel=10; next FETCH.
REQ-022 MEM SHALL assert mem_read (lw) or mem_write (sw) until mem_ack. On ack: lw -> WB; sw -> FETCH.
REQ-023 WB SHALL assert reg_write=1 for one cycle, with wb_sel=01 for lw and 00 otherwise; next FETCH.
REQ-024 instret SHALL increment by 1 on each instruction's final cycle (WB, sw MEM ack, beq/jal EXEC); it SHALL wrap modulo 2^INSTRET_W.
REQ-025 Minimum cycles with immediate ack: R/I 4, lw 5, sw 4, beq 3, jal 3; each mem_ack-low cycle adds one.
REQ-026 TRAP SHALL hold all strobes 0 and illegal=1 until reset; instret frozen.
REQ-027 Strobes SHALL be Moore/decoded from state+ins only; mem_ack only gates pc_we/ir_we/transitions.

Reset
REQ-028 reset=1 SHALL, at the next edge, force state FETCH, illegal=0, instret=0, regardless of current state or pending mem_ack.
REQ-029 During reset cycle outputs SHALL be 0; mem_read asserts first cycle after reset deasserts.

Configuration
REQ-030 Macro MCTRL_JAL_EN defined: jal supported per REQ-021. Undefined: opcode 1101111 is illegal (TRAP), pc_src=10 and wb_sel=10 never driven.

Structure
REQ-031 Shared package mctrl_pkg SHALL hold state enum, opcode constants, alu_op constants, pc_src/wb_sel encodings.
REQ-032 One sub-module mctrl_decode (combinational ins -> alu_op, alu_src, class, illegal) SHALL be used; the FSM and counter stay in multicycle_ctrl.

Verification
REQ-033 add x3,x1,x2 (0x002081B3), mem_ack tied 1 -> 4 cycles; reg_write=1, alu_op=010, wb_sel=00 in cycle 4; instret=1.
REQ-034 lw (0x0000A183), ack delayed 2 cycles in MEM -> 7 cycles; wb_sel=01 in WB.
REQ-035 beq with zero=1, then zero=0 -> pc_we=1, pc_src=01 in EXEC, then pc_we=0; 3 cycles each.
REQ-036 ins=0xFFFFFFFF -> TRAP after DECODE; illegal=1 persists 10 cycles; reset -> FETCH, illegal=0.
REQ-037 Reset asserted in MEM of sw with mem_ack=1 -> no mem_write after reset; instret=0.
REQ-038 jal (0x008000EF), with and without MCTRL_JAL_EN -> pc_src=10, reg_write=1, wb_sel=10; without: illegal=1.
